wme_chan_mgr: RTL and testbench



---
 rtl/wme_chan_mgr.sv | 162 ++++++++++++++++
 tb/tb_wme_chan_mgr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wme_chan_mgr.sv
// Weight-manager channel store: NTI x DEPTH signed weights driven in parallel, loaded by a debug command engine.
// Optional shadow bank with atomic commit is enabled by defining WME_SHADOW_EN.
module wme_chan_mgr #(
   parameter int NTI   = 16,
   parameter int DEPTH = 30,
   parameter int WIDTH = 10,
   parameter int LW    = $clog2(NTI),
   parameter int TW    = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rstb,
   input  logic [WIDTH-1:0]             dbg_data,
   input  logic [3+LW+TW-1:0]           dbg_inst,
   input  logic                         dbg_exec,
   output logic [WIDTH-1:0]             dbg_read,
   output logic                         dbg_busy,
   output logic                         dbg_done,
   output logic                         dbg_err,
   output logic [NTI*DEPTH*WIDTH-1:0]   weights,
   output logic                         wme_upd
);

   // state   | meaning
   // S_IDLE  | waiting for a rising edge on dbg_exec
   // S_CLEAR | zeroing one entry per cycle, lane-major
   // S_DONE  | one-cycle completion, dbg_done high
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   localparam int NE = NTI * DEPTH;
   localparam int IW = $clog2(NE);

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_WRITE  = 3'd1;
   localparam logic [2:0] OP_READ   = 3'd2;
   localparam logic [2:0] OP_FILL   = 3'd3;
   localparam logic [2:0] OP_CLEAR  = 3'd4;
   localparam logic [2:0] OP_COMMIT = 3'd5;

   state_t            state_q, state_d;
   logic              exec_q;
   logic [IW-1:0]     idx_q;
   logic              err_q;
   logic              upd_q;
   logic [WIDTH-1:0]  read_q;

   // bank is the command target: the active bank, or the shadow when enabled
   logic [WIDTH-1:0]  bank [NE];
`ifdef WME_SHADOW_EN
   logic [WIDTH-1:0]  act [NE];
`endif

   logic [2:0]        op;
   logic [LW-1:0]     lane;
   logic [TW-1:0]     tap;
   logic              rise, launch, bad_op, bad_rng, ok, clr_last;
   logic              launch_upd, clr_upd;
   logic [IW-1:0]     ent_idx;

   assign op   = dbg_inst[LW+TW +: 3];
   assign lane = dbg_inst[TW +: LW];
   assign tap  = dbg_inst[0 +: TW];

   assign rise     = dbg_exec & ~exec_q;
   assign launch   = rise & (state_q == S_IDLE);
   assign bad_op   = (op > OP_COMMIT);
   assign bad_rng  = (((op == OP_WRITE) || (op == OP_READ)) &&
                      ((int'(lane) >= NTI) || (int'(tap) >= DEPTH))) ||
                     ((op == OP_FILL) && (int'(tap) >= DEPTH));
   assign ok       = launch & ~bad_op & ~bad_rng;
   assign ent_idx  = IW'(lane) * IW'(DEPTH) + IW'(tap);
   assign clr_last = (state_q == S_CLEAR) && (idx_q == IW'(NE - 1));

`ifdef WME_SHADOW_EN
   assign launch_upd = ok && (op == OP_COMMIT);
   assign clr_upd    = 1'b0;
`else
   assign launch_upd = ok && ((op == OP_WRITE) || (op == OP_FILL));
   assign clr_upd    = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (launch) state_d = (op == OP_CLEAR) ? S_CLEAR : S_DONE;
         S_CLEAR: if (clr_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= S_IDLE;
         exec_q  <= 1'b0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         upd_q   <= 1'b0;
         read_q  <= '0;
      end else begin
         state_q <= state_d;
         exec_q  <= dbg_exec;

         if (launch)
            idx_q <= '0;
         else if (state_q == S_CLEAR)
            idx_q <= clr_last ? '0 : idx_q + 1'b1;

         // a dropped edge while busy counts as an error just like a bad command
         if (launch && (op == OP_NOP))
            err_q <= 1'b0;
         else if ((rise && (state_q != S_IDLE)) || (launch && (bad_op || bad_rng)))
            err_q <= 1'b1;

         if (ok && (op == OP_READ))
            read_q <= bank[ent_idx];

         if (launch)
            upd_q <= launch_upd;
         else if (clr_last)
            upd_q <= clr_upd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         for (int i = 0; i < NE; i++) begin
            bank[i] <= '0;
`ifdef WME_SHADOW_EN
            act[i]  <= '0;
`endif
         end
      end else begin
         if (ok && (op == OP_WRITE))
            bank[ent_idx] <= dbg_data;
         if (ok && (op == OP_FILL))
            for (int l = 0; l < NTI; l++)
               bank[l*DEPTH + int'(tap)] <= dbg_data;
         if (state_q == S_CLEAR)
            bank[idx_q] <= '0;
`ifdef WME_SHADOW_EN
         if (ok && (op == OP_COMMIT))
            for (int i = 0; i < NE; i++)
               act[i] <= bank[i];
`endif
      end
   end

   for (genvar g = 0; g < NE; g++) begin : g_w
`ifdef WME_SHADOW_EN
      assign weights[g*WIDTH +: WIDTH] = act[g];
`else
      assign weights[g*WIDTH +: WIDTH] = bank[g];
`endif
   end

   assign dbg_read = read_q;
   assign dbg_busy = (state_q != S_IDLE);
   assign dbg_done = (state_q == S_DONE);
   assign dbg_err  = err_q;
   assign wme_upd  = upd_q & (state_q == S_DONE);

endmodule

// File: tb/tb_wme_chan_mgr.sv
// Directed bench for wme_chan_mgr at NTI=16, DEPTH=30, WIDTH=10; expectations follow WME_SHADOW_EN.
module tb_wme_chan_mgr;

   localparam int NTI = 16, DEPTH = 30, WIDTH = 10;
`ifdef WME_SHADOW_EN
   localparam bit SH = 1'b1;
`else
   localparam bit SH = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       rstb;
   logic [WIDTH-1:0]           dbg_data;
   logic [11:0]                dbg_inst;
   logic                       dbg_exec;
   logic [WIDTH-1:0]           dbg_read;
   logic                       dbg_busy, dbg_done, dbg_err, wme_upd;
   logic [NTI*DEPTH*WIDTH-1:0] weights;

   int checks = 0;
   int errors = 0;
   int k;
   logic all_ok;

   wme_chan_mgr #(.NTI(NTI), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rstb(rstb), .dbg_data(dbg_data), .dbg_inst(dbg_inst),
      .dbg_exec(dbg_exec), .dbg_read(dbg_read), .dbg_busy(dbg_busy),
      .dbg_done(dbg_done), .dbg_err(dbg_err), .weights(weights), .wme_upd(wme_upd)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] w(input int l, input int t);
      return weights[(l*DEPTH + t)*WIDTH +: WIDTH];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [2:0] op, input logic [3:0] lane,
                         input logic [4:0] tap, input logic [WIDTH-1:0] data);
      dbg_inst = {op, lane, tap};
      dbg_data = data;
      dbg_exec = 1'b1;
      step();
   endtask

   task automatic release_exec();
      dbg_exec = 1'b0;
      step();
   endtask

   initial begin
      rstb = 1'b0; dbg_exec = 1'b0; dbg_inst = '0; dbg_data = '0;
      step(); step();
      chk("rst_read", dbg_read, 0);
      chk("rst_busy", dbg_busy, 0);
      chk("rst_done", dbg_done, 0);
      chk("rst_err", dbg_err, 0);
      chk("rst_upd", wme_upd, 0);
      chk("rst_weights_zero", weights == '0, 1);
      rstb = 1'b1;
      step();

      // WRITE (3,7) = -5
      launch(3'd1, 4'd3, 5'd7, 10'h3FB);
      chk("wr_entry", w(3, 7), SH ? 10'h000 : 10'h3FB);
      chk("wr_done", dbg_done, 1);
      chk("wr_busy", dbg_busy, 1);
      chk("wr_upd", wme_upd, SH ? 0 : 1);
      release_exec();
      chk("wr_done_pulse", dbg_done, 0);
      chk("wr_busy_end", dbg_busy, 0);

      // READ (3,7)
      launch(3'd2, 4'd3, 5'd7, 10'h000);
      chk("rd_value", dbg_read, 10'h3FB);
      chk("rd_done", dbg_done, 1);
      chk("rd_upd", wme_upd, 0);
      release_exec();

      // FILL tap 29 = 511
      launch(3'd3, 4'd0, 5'd29, 10'd511);
      all_ok = 1'b1;
      for (int l = 0; l < NTI; l++)
         if (w(l, 29) !== (SH ? 10'd0 : 10'd511)) all_ok = 1'b0;
      chk("fill_all_lanes", all_ok, 1);
      chk("fill_other_tap", w(3, 7), SH ? 10'h000 : 10'h3FB);
      chk("fill_upd", wme_upd, SH ? 0 : 1);
      release_exec();
      launch(3'd2, 4'd15, 5'd29, 10'h000);
      chk("fill_readback", dbg_read, 10'd511);
      release_exec();

      // errored READ at tap 31 keeps dbg_read
      launch(3'd2, 4'd0, 5'd31, 10'h000);
      chk("bad_rd_err", dbg_err, 1);
      chk("bad_rd_keep", dbg_read, 10'd511);
      release_exec();
      launch(3'd0, 4'd0, 5'd0, 10'h000);
      chk("nop_clr_err0", dbg_err, 0);
      release_exec();

      // CLEAR with exec held, then a second edge while busy
      launch(3'd4, 4'd0, 5'd0, 10'h000);
      k = 1;
      chk("clr_busy_first", dbg_busy, 1);
      chk("clr_no_done_first", dbg_done, 0);
      while (k < 481) begin
         if (k == 2)  dbg_exec = 1'b0;
         if (k == 10) dbg_exec = 1'b1;
         step();
         k++;
         if (k == 3)  chk("clr_pre_idx29", w(0, 29), SH ? 10'd0 : 10'd511);
         if (k == 12) chk("clr_busy_edge_err", dbg_err, 1);
         if (k == 31) begin
            chk("clr_idx29_zero", w(0, 29), 0);
            chk("clr_idx59_pending", w(1, 29), SH ? 10'd0 : 10'd511);
         end
         if (k == 480) begin
            chk("clr_busy_480", dbg_busy, 1);
            chk("clr_done_480", dbg_done, 0);
         end
      end
      chk("clr_done_481", dbg_done, 1);
      chk("clr_upd_481", wme_upd, SH ? 0 : 1);
      chk("clr_all_zero", weights == '0, 1);
      chk("clr_err_held", dbg_err, 1);
      step();
      chk("clr_idle_held_exec", dbg_busy, 0);
      step();
      chk("held_exec_no_relaunch", dbg_busy, 0);
      release_exec();
      launch(3'd0, 4'd0, 5'd0, 10'h000);
      chk("nop_clr_err1", dbg_err, 0);
      release_exec();

      // WRITE tap 30 and illegal op 7
      launch(3'd1, 4'd2, 5'd30, 10'd1);
      chk("bad_tap_err", dbg_err, 1);
      chk("bad_tap_done", dbg_done, 1);
      chk("bad_tap_upd", wme_upd, 0);
      chk("bad_tap_nowrite", weights == '0, 1);
      release_exec();
      launch(3'd0, 4'd0, 5'd0, 10'h000);
      chk("nop_clr_err2", dbg_err, 0);
      release_exec();
      launch(3'd7, 4'd1, 5'd1, 10'd9);
      chk("op7_err", dbg_err, 1);
      chk("op7_done", dbg_done, 1);
      chk("op7_nowrite", weights == '0, 1);
      release_exec();
      launch(3'd0, 4'd0, 5'd0, 10'h000);
      chk("nop_clr_err3", dbg_err, 0);
      release_exec();

      // reset at clear index 100, with err set and a nonzero entry
      launch(3'd1, 4'd5, 5'd5, 10'd77);
      release_exec();
      launch(3'd6, 4'd0, 5'd0, 10'h000);
      release_exec();
      launch(3'd4, 4'd0, 5'd0, 10'h000);
      k = 1;
      while (k < 101) begin
         step();
         k++;
      end
      chk("pre_rst_busy", dbg_busy, 1);
      rstb = 1'b0;
      dbg_exec = 1'b0;
      step();
      chk("mrst_busy", dbg_busy, 0);
      chk("mrst_done", dbg_done, 0);
      chk("mrst_err", dbg_err, 0);
      chk("mrst_read", dbg_read, 0);
      chk("mrst_upd", wme_upd, 0);
      chk("mrst_weights", weights == '0, 1);
      rstb = 1'b1;
      step();

      // WRITE (0,0) = 12 then COMMIT
      launch(3'd1, 4'd0, 5'd0, 10'd12);
      chk("w00_entry", w(0, 0), SH ? 10'd0 : 10'd12);
      chk("w00_upd", wme_upd, SH ? 0 : 1);
      chk("w00_done", dbg_done, 1);
      release_exec();
      launch(3'd2, 4'd0, 5'd0, 10'h000);
      chk("w00_read", dbg_read, 10'd12);
      release_exec();
      launch(3'd5, 4'd0, 5'd0, 10'h000);
      chk("commit_entry", w(0, 0), 10'd12);
      chk("commit_done", dbg_done, 1);
      chk("commit_upd", wme_upd, SH ? 1 : 0);
      chk("commit_err", dbg_err, 0);
      release_exec();
      chk("commit_upd_pulse", wme_upd, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
